atconv_param: RTL and testbench
===============================

// Module: atconv_param
// PURPOSE
//  Parametrised dilated (atrous) 3x3 convolution engine with ReLU and optional 2x2 max-pool.
//  - Reads an IMG_W x IMG_W signed fixed-point image from the image ROM port.
//  - Writes layer 0 (conv+ReLU) to local memory bank csel=0, then layer 1 (pooled, ceil to integer) to bank csel=1.
//  - Successor of the fixed 64x64/dilation-2 engine: image size, data width, dilation and bias are now parameters.
// PARAMETERS
//  IMG_W     64   image side in pixels; power of 2, >= 8
//  DW        13   data width, signed two's complement, Qx.FRAC
//  FRAC      4    fractional bits of idata/cdata
//  DIL       2    dilation distance in pixels; 1 <= DIL <= IMG_W/4
//  BIAS_MAG  12   bias magnitude in LSBs, subtracted from every conv sum (12 = 0.75 in Q.4)
//  AW        2*$clog2(IMG_W)  address width (localparam, derived)
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-high reset
//  ready     in   1   image available; sampled only in IDLE
//  busy      out  1   high from run start until after the last write
//  iaddr     out  AW  image read address; row*IMG_W+col
//  idata     in   DW  image data; valid the cycle after iaddr
//  cwr       out  1   local memory write strobe
//  caddr_wr  out  AW  local memory write address
//  cdata_wr  out  DW  local memory write data
//  crd       out  1   local memory read strobe
//  caddr_rd  out  AW  local memory read address
//  cdata_rd  in   DW  local memory read data; valid the cycle after caddr_rd
//  csel      out  1   bank select: 0 = layer 0, 1 = layer 1
// BEHAVIOUR
//  Reset values: busy=0, cwr=0, crd=0, csel=0; iaddr, caddr_wr, caddr_rd, cdata_wr = 0. FSM goes to IDLE; counters clear.
//  Reset mid-run aborts at once. No partial-write completion. A fresh ready is required to restart.
//  FSM states:
//   IDLE:  ready=1 -> busy=1 next cycle, go to FETCH. ready is ignored while busy.
//   FETCH: 9 consecutive cycles issue tap addresses in row-major order, top-left first.
//          idata is captured one cycle after each address, so FETCH lasts 10 cycles.
//          Tap (dr,dc) with dr,dc in {-DIL,0,+DIL}: row/col clamped to [0,IMG_W-1] (replicate padding).
//   CONV:  1 cycle. Compute sum, subtract BIAS_MAG, apply ReLU; latch result into cdata_wr.
//   WR0:   1 cycle. cwr=1, csel=0, caddr_wr=pixel index.
//          Last pixel (IMG_W*IMG_W-1) -> POOL, else -> FETCH for the next pixel. Total 12 cycles/pixel.
//   POOL:  2x2 stride-2 pooling. Issue 4 crd reads with csel=0 at (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1).
//          Track the running max. 5 cycles.
//   WR1:   1 cycle. cwr=1, csel=1, caddr_wr = r*(IMG_W/2)+c.
//          Last pooled pixel -> DONE, else -> POOL.
//   DONE:  busy=0 next cycle, go to IDLE.
//  Strobes: cwr and crd are single-cycle pulses and never high together; csel is stable while a strobe is high.
//  Arithmetic:
//   - Weights: centre +1; edge taps (left/right) -1/4; top/bottom -1/8; corners -1/16.
//   - Each weighted tap is an arithmetic right shift of the sample (floor).
//   - Accumulator is DW+3 bits signed; saturate to DW on positive overflow. Negative result -> 0 (ReLU).
//   - Ceil at pooling: if max[FRAC-1:0]!=0, output (max + 2^FRAC) with frac bits cleared; else max unchanged.
//  Boundaries: corner pixels clamp in both axes, so duplicate addresses are expected.
//   Pixel counter and pool counter wrap to 0 at DONE.
// CONFIGURATION
//  ATCONV_POOL_EN defined: full flow as above (layer 0 then layer 1).
//  ATCONV_POOL_EN undefined: POOL/WR1 are not built. WR0 on the last pixel goes to DONE;
//   csel is held at 0; crd is tied to 0; caddr_rd is tied to 0.
// TESTING (IMG_W=64, DW=13, FRAC=4, DIL=2, BIAS_MAG=12, ATCONV_POOL_EN defined)
//  1. Constant image 0x0010 everywhere -> every layer-0 word 0x0000 and every layer-1 word 0x0000.
//     busy falls 4096*12+1024*6+1 cycles after it rises.
//  2. Impulse 0x0100 at (32,32), rest 0:
//     - layer0[32*64+32]=0x00F4
//     - layer0[32*64+30]=0x0000
//     - layer1[16*32+16]=0x0100 (ceil)
//  3. Impulse 0x0100 at (0,0): taps clamp, conv = 16 - 4 - 2 - 1 ... (corner weights stacked).
//     Check layer0[0] against the reference model and check that no iaddr exceeds 4095.
//  4. Assert reset for 1 cycle during FETCH of pixel 100:
//     - busy, cwr and crd drop at once; no further writes.
//     - A new ready pulse restarts at pixel 0.
//  5. Hold ready=1 for the whole run -> exactly one run; busy re-asserts only after DONE/IDLE.
//  6. ATCONV_POOL_EN undefined, test 2 image -> layer0 identical to test 2; zero writes with csel=1; busy falls 4096*12+1 cycles after rise.

Source files
------------

// File: rtl/atconv_param.sv
// atconv_param
//   Dilated (atrous) 3x3 convolution engine with bias, ReLU and an optional
//   2x2 stride-2 max-pool whose result is rounded up to an integer.
//   Layer 0 (conv+ReLU) is written to bank csel=0 in raster order; layer 1
//   (pooled, ceil) is then written to bank csel=1.
//
// Build option: define ATCONV_POOL_EN to build the pooling layer. Without it
//   the run ends after layer 0, csel/crd/caddr_rd are tied to 0.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   ready     start request, sampled only while idle
//   busy      high from run start until after the last write
//   iaddr     image read address (row*IMG_W+col); idata valid one cycle later
//   idata     image sample, signed fixed point with FRAC fraction bits
//   cwr       local memory write strobe (single-cycle pulse)
//   caddr_wr  local memory write address
//   cdata_wr  local memory write data
//   crd       local memory read strobe (single-cycle pulse)
//   caddr_rd  local memory read address; cdata_rd valid one cycle later
//   cdata_rd  local memory read data
//   csel      bank select: 0 = layer 0, 1 = layer 1
module atconv_param #(
    parameter int IMG_W    = 64,
    parameter int DW       = 13,
    parameter int FRAC     = 4,
    parameter int DIL      = 2,
    parameter int BIAS_MAG = 12,
    localparam int AW      = 2 * $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          csel
);
    localparam int LW  = AW / 2;
    localparam int ACW = DW + 3;
    localparam logic [AW-1:0]         LAST_PIX = '1;
    localparam logic signed [LW+1:0]  DIL_S    = (LW+2)'(DIL);
    localparam logic signed [LW+1:0]  EDGE_S   = (LW+2)'(IMG_W - 1);
    localparam logic signed [ACW-1:0] BIAS_S   = ACW'(BIAS_MAG);
    localparam logic signed [ACW-1:0] SAT_S    = ACW'((1 << (DW - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_WR0,
`ifdef ATCONV_POOL_EN
        S_POOL,
        S_WR1,
`endif
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic [AW-1:0]         pix_q, pix_d;
    logic [3:0]            tap_q, tap_d;
    logic signed [ACW-1:0] acc_q, acc_d;
    logic [AW-1:0]         iaddr_q, iaddr_d;
    logic                  cwr_q, cwr_d;
    logic [AW-1:0]         caddr_wr_q, caddr_wr_d;
    logic [DW-1:0]         cdata_wr_q, cdata_wr_d;

    // Offset one coordinate by -DIL/0/+DIL and clamp to the image (replicate padding).
    function automatic logic [LW-1:0] clamp_off(input logic [LW-1:0] base, input logic [1:0] sel);
        logic signed [LW+1:0] v;
        logic [LW-1:0]        r;
        v = signed'({2'b00, base});
        if (sel == 2'd0) v = v - DIL_S;
        else if (sel == 2'd2) v = v + DIL_S;
        if (v[LW+1]) r = '0;
        else if (v > EDGE_S) r = '1;
        else r = v[LW-1:0];
        return r;
    endfunction

    // Tap k in row-major order, top-left first.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] pix, input logic [3:0] k);
        logic [1:0] rs, cs;
        case (k)
            4'd0:    {rs, cs} = 4'b0000;
            4'd1:    {rs, cs} = 4'b0001;
            4'd2:    {rs, cs} = 4'b0010;
            4'd3:    {rs, cs} = 4'b0100;
            4'd4:    {rs, cs} = 4'b0101;
            4'd5:    {rs, cs} = 4'b0110;
            4'd6:    {rs, cs} = 4'b1000;
            4'd7:    {rs, cs} = 4'b1001;
            default: {rs, cs} = 4'b1010;
        endcase
        return {clamp_off(pix[AW-1:LW], rs), clamp_off(pix[LW-1:0], cs)};
    endfunction

    // Weighted contribution: centre +1, L/R -1/4, T/B -1/8, corners -1/16 (floor shifts).
    function automatic logic signed [ACW-1:0] tap_term(input logic [DW-1:0] d, input logic [3:0] k);
        logic signed [ACW-1:0] x;
        logic signed [ACW-1:0] t;
        x = signed'({{3{d[DW-1]}}, d});
        case (k)
            4'd4:       t = x;
            4'd3, 4'd5: t = -(x >>> 2);
            4'd1, 4'd7: t = -(x >>> 3);
            default:    t = -(x >>> 4);
        endcase
        return t;
    endfunction

    logic signed [ACW-1:0] conv_res;
    logic [DW-1:0]         relu_val;

    always_comb begin
        conv_res = acc_q - BIAS_S;
        if (conv_res[ACW-1]) relu_val = '0;
        else if (conv_res > SAT_S) relu_val = SAT_S[DW-1:0];
        else relu_val = conv_res[DW-1:0];
    end

`ifdef ATCONV_POOL_EN
    localparam logic [DW-1:0]   ONE_F     = DW'(1 << FRAC);
    localparam logic [DW-1:0]   FMASK     = DW'((1 << FRAC) - 1);
    localparam logic [AW-3:0]   LAST_POOL = '1;

    logic          csel_q, csel_d;
    logic          crd_q, crd_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic [AW-3:0] pool_q, pool_d;
    logic [2:0]    pstep_q, pstep_d;
    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] mx_new, ceil_val;

    // Window element s: s[1] selects row 2r+1, s[0] selects column 2c+1.
    function automatic logic [AW-1:0] pool_addr(input logic [AW-3:0] idx, input logic [1:0] s);
        return {idx[AW-3:LW-1], s[1], idx[LW-2:0], s[0]};
    endfunction

    // Read s returns on step s+1; step 1 seeds the running max.
    always_comb begin
        if (pstep_q == 3'd1 || $signed(cdata_rd) > $signed(max_q)) mx_new = cdata_rd;
        else mx_new = max_q;
        if (mx_new[FRAC-1:0] != '0) ceil_val = (mx_new + ONE_F) & ~FMASK;
        else ceil_val = mx_new;
    end

    assign csel     = csel_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
`else
    logic unused_rd;
    assign unused_rd = (^cdata_rd) ^ (FRAC > 0);
    assign csel      = 1'b0;
    assign crd       = 1'b0;
    assign caddr_rd  = '0;
`endif

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        pix_d      = pix_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        iaddr_d    = iaddr_q;
        cwr_d      = 1'b0;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
`ifdef ATCONV_POOL_EN
        csel_d     = 1'b0;
        crd_d      = 1'b0;
        caddr_rd_d = caddr_rd_q;
        pool_d     = pool_q;
        pstep_d    = pstep_q;
        max_d      = max_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                    tap_d   = '0;
                    iaddr_d = tap_addr(pix_q, 4'd0);
                end
            end
            // Cycle t presents tap t; its sample arrives at cycle t+1, so the
            // accumulator is cleared at t=0 and collects taps on t=1..9.
            S_FETCH: begin
                if (tap_q == 4'd0) acc_d = '0;
                else acc_d = acc_q + tap_term(idata, tap_q - 4'd1);
                if (tap_q < 4'd8) iaddr_d = tap_addr(pix_q, tap_q + 4'd1);
                if (tap_q == 4'd9) begin
                    tap_d   = '0;
                    state_d = S_CONV;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_CONV: begin
                cdata_wr_d = relu_val;
                caddr_wr_d = pix_q;
                cwr_d      = 1'b1;
                state_d    = S_WR0;
            end
            S_WR0: begin
                pix_d = pix_q + AW'(1);
                if (pix_q == LAST_PIX) begin
`ifdef ATCONV_POOL_EN
                    state_d    = S_POOL;
                    pstep_d    = '0;
                    crd_d      = 1'b1;
                    caddr_rd_d = pool_addr(pool_q, 2'd0);
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_FETCH;
                    iaddr_d = tap_addr(pix_q + AW'(1), 4'd0);
                end
            end
`ifdef ATCONV_POOL_EN
            S_POOL: begin
                if (pstep_q != 3'd0) max_d = mx_new;
                if (pstep_q < 3'd3) begin
                    crd_d      = 1'b1;
                    caddr_rd_d = pool_addr(pool_q, pstep_q[1:0] + 2'd1);
                end
                if (pstep_q == 3'd4) begin
                    pstep_d    = '0;
                    state_d    = S_WR1;
                    cwr_d      = 1'b1;
                    csel_d     = 1'b1;
                    caddr_wr_d = {2'b00, pool_q};
                    cdata_wr_d = ceil_val;
                end else begin
                    pstep_d = pstep_q + 3'd1;
                end
            end
            S_WR1: begin
                pool_d = pool_q + (AW-2)'(1);
                if (pool_q == LAST_POOL) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_POOL;
                    pstep_d    = '0;
                    crd_d      = 1'b1;
                    caddr_rd_d = pool_addr(pool_q + (AW-2)'(1), 2'd0);
                end
            end
`endif
            S_DONE: begin
                busy_d  = 1'b0;
                pix_d   = '0;
`ifdef ATCONV_POOL_EN
                pool_d  = '0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            pix_q      <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            iaddr_q    <= '0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            pix_q      <= pix_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            iaddr_q    <= iaddr_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

`ifdef ATCONV_POOL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csel_q     <= 1'b0;
            crd_q      <= 1'b0;
            caddr_rd_q <= '0;
            pool_q     <= '0;
            pstep_q    <= '0;
            max_q      <= '0;
        end else begin
            csel_q     <= csel_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            pool_q     <= pool_d;
            pstep_q    <= pstep_d;
            max_q      <= max_d;
        end
    end
`endif

    assign busy     = busy_q;
    assign iaddr    = iaddr_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_atconv_param.sv
// Bench for atconv_param on a 16x16 image (DIL=2, Q.4, bias 0.75).
// Expected write streams are pushed into a queue before each run; a negedge
// monitor pops one entry per cwr pulse and compares bank, address and data.
module tb_atconv_param;
    localparam int IMG_W = 16;
    localparam int DW    = 13;
    localparam int AW    = 8;
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int NPOOL = NPIX / 4;
    localparam int BUDGET = 5000;
`ifdef ATCONV_POOL_EN
    localparam int RUN_CYC = NPIX * 12 + NPOOL * 6 + 1;
`else
    localparam int RUN_CYC = NPIX * 12 + 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata = '0;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd = '0;
    logic          csel;

    atconv_param #(.IMG_W(IMG_W), .DW(DW), .FRAC(4), .DIL(2), .BIAS_MAG(12)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] img [NPIX];
    logic [DW-1:0] l0  [NPIX];
    logic [DW-1:0] l1  [NPOOL];

    always @(posedge clk) idata <= img[iaddr];
    always @(posedge clk) if (crd) cdata_rd <= csel ? l1[caddr_rd[5:0]] : l0[caddr_rd];
    always @(posedge clk) begin
        if (cwr) begin
            if (csel) l1[caddr_wr[5:0]] <= cdata_wr;
            else l0[caddr_wr] <= cdata_wr;
        end
    end

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          dc;
    } exp_t;

    exp_t exp_q[$];
    int n_pass  = 0;
    int n_total = 0;
    int n_wr    = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (crd) check(!csel && !cwr, "rd_strobe", {30'd0, csel, cwr}, 32'd0);
        if (cwr) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_wr", {10'd0, csel, caddr_wr, cdata_wr}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.dc)
                    check({csel, caddr_wr, crd} == {mon_e.sel, mon_e.addr, 1'b0}, "wr_addr",
                          {22'd0, csel, caddr_wr, crd}, {22'd0, mon_e.sel, mon_e.addr, 1'b0});
                else
                    check({csel, caddr_wr, cdata_wr, crd} == {mon_e.sel, mon_e.addr, mon_e.data, 1'b0}, "wr",
                          {9'd0, csel, caddr_wr, cdata_wr, crd}, {9'd0, mon_e.sel, mon_e.addr, mon_e.data, 1'b0});
            end
        end
    end

    task automatic fill(input logic [DW-1:0] bg, input int hp, input logic [DW-1:0] hv);
        for (int i = 0; i < NPIX; i++) begin
            img[i] = (i == hp) ? hv : bg;
            l0[i]  = 13'h1555;
        end
        for (int i = 0; i < NPOOL; i++) l1[i] = 13'h1555;
    endtask

    // Whole layer is zero except one hot pixel / one hot pooled word.
    task automatic push_run(input int hp, input logic [DW-1:0] hv, input int hq,
                            input logic [DW-1:0] hqv, input bit qdc);
        exp_t e;
        exp_t pe [NPOOL];
        for (int p = 0; p < NPIX; p++) begin
            e.sel = 1'b0; e.addr = AW'(p); e.data = (p == hp) ? hv : '0; e.dc = 1'b0;
            exp_q.push_back(e);
        end
        for (int p = 0; p < NPOOL; p++) begin
            pe[p].sel = 1'b1; pe[p].addr = AW'(p);
            pe[p].data = (p == hq) ? hqv : '0; pe[p].dc = (p == hq) && qdc;
        end
`ifdef ATCONV_POOL_EN
        for (int p = 0; p < NPOOL; p++) exp_q.push_back(pe[p]);
`endif
    endtask

    // Pixel 0 taps after clamping: (0,0)x2,(0,2),(0,0)x2,(0,2),(2,0)x2,(2,2).
    logic [AW-1:0] tap0_addr [9] = '{8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd2, 8'd32, 8'd32, 8'd34};

    task automatic run_img(input bit hold, input bit chk_addr, input int limit, output int dur);
        int t;
        dur = 0;
        @(negedge clk);
        ready = 1'b1;
        t = 0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        if (!busy) begin
            check(1'b0, "busy_rise", 32'd0, 32'd1);
            ready = 1'b0;
            return;
        end
        if (!hold) ready = 1'b0;
        if (chk_addr) begin
            for (int k = 0; k < 9; k++) begin
                check(iaddr == tap0_addr[k], "tap_addr", 32'(iaddr), 32'(tap0_addr[k]));
                @(negedge clk);
                dur++;
            end
        end
        while (busy && dur < limit) begin @(negedge clk); dur++; end
        ready = 1'b0;
    endtask

    task automatic end_run(input int dur);
        check(dur == RUN_CYC, "busy_len", 32'(dur), 32'(RUN_CYC));
        check(exp_q.size() == 0, "queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dur;
        int base;
        reset = 1'b1;
        ready = 1'b0;
        fill('0, -1, '0);
        repeat (3) @(negedge clk);
        check(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
        check(cwr == 1'b0, "rst_cwr", 32'(cwr), 32'd0);
        check(crd == 1'b0, "rst_crd", 32'(crd), 32'd0);
        check(csel == 1'b0, "rst_csel", 32'(csel), 32'd0);
        check(iaddr == '0, "rst_iaddr", 32'(iaddr), 32'd0);
        check(caddr_wr == '0, "rst_caddr_wr", 32'(caddr_wr), 32'd0);
        check(cdata_wr == '0, "rst_cdata_wr", 32'(cdata_wr), 32'd0);
        check(caddr_rd == '0, "rst_caddr_rd", 32'(caddr_rd), 32'd0);
        reset = 1'b0;

        // Constant 1.0: 16 - 2*4 - 2*2 - 4*1 = 0, minus bias -> ReLU 0.
        fill(13'h0010, -1, '0);
        push_run(-1, '0, -1, '0, 1'b0);
        run_img(1'b0, 1'b0, BUDGET, dur);
        end_run(dur);

        // Centre impulse 16.0 at (8,8): 256-12 = 0xF4; pooled ceil -> 0x100.
        fill('0, 136, 13'h0100);
        push_run(136, 13'h00F4, 36, 13'h0100, 1'b0);
        run_img(1'b0, 1'b0, BUDGET, dur);
        end_run(dur);
        check(l0[136] == 13'h00F4, "l0_centre", 32'(l0[136]), 32'h00F4);
        check(l0[134] == 13'h0000, "l0_left2", 32'(l0[134]), 32'h0000);
`ifdef ATCONV_POOL_EN
        check(l1[36] == 13'h0100, "l1_centre", 32'(l1[36]), 32'h0100);
`endif

        // Corner impulse: clamped taps stack, 256-64-32-16-12 = 0x84; ceil -> 0x90.
        fill('0, 0, 13'h0100);
        push_run(0, 13'h0084, 0, 13'h0090, 1'b0);
        run_img(1'b0, 1'b1, BUDGET, dur);
        end_run(dur);
        check(l0[0] == 13'h0084, "l0_corner", 32'(l0[0]), 32'h0084);
`ifdef ATCONV_POOL_EN
        check(l1[0] == 13'h0090, "l1_corner", 32'(l1[0]), 32'h0090);
`endif

        // Max centre among min neighbours: 4095+4096-12 saturates to 0xFFF.
        fill(13'h1000, 136, 13'h0FFF);
        push_run(136, 13'h0FFF, 36, '0, 1'b1);
        run_img(1'b0, 1'b0, BUDGET, dur);
        end_run(dur);
        check(l0[136] == 13'h0FFF, "l0_sat", 32'(l0[136]), 32'h0FFF);

        // Reset in the FETCH of pixel 100, then a fresh start from pixel 0.
        fill('0, 136, 13'h0100);
        push_run(136, 13'h00F4, 36, 13'h0100, 1'b0);
        base = n_wr;
        run_img(1'b0, 1'b0, 1203, dur);
        #1;
        check(n_wr - base == 100, "wr_before_abort", 32'(n_wr - base), 32'd100);
        reset = 1'b1;
        #1;
        check(busy == 1'b0, "abort_busy", 32'(busy), 32'd0);
        check(cwr == 1'b0, "abort_cwr", 32'(cwr), 32'd0);
        check(crd == 1'b0, "abort_crd", 32'(crd), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        base = n_wr;
        repeat (40) @(negedge clk);
        #1;
        check(n_wr == base, "no_wr_after_abort", 32'(n_wr - base), 32'd0);
        check(busy == 1'b0, "idle_after_abort", 32'(busy), 32'd0);
        push_run(136, 13'h00F4, 36, 13'h0100, 1'b0);
        run_img(1'b0, 1'b1, BUDGET, dur);
        end_run(dur);
        check(l0[136] == 13'h00F4, "l0_restart", 32'(l0[136]), 32'h00F4);

        // ready held high for the whole run: one run only, ready ignored while busy.
        fill(13'h0010, -1, '0);
        push_run(-1, '0, -1, '0, 1'b0);
        run_img(1'b1, 1'b0, BUDGET, dur);
        end_run(dur);
        repeat (5) @(negedge clk);
        check(busy == 1'b0, "hold_no_rerun", 32'(busy), 32'd0);
        check(exp_q.size() == 0, "hold_no_extra_wr", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
